// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared state encoding and default geometry for the RAM-backed FIFO controller
package ram_fifo_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;
  typedef enum logic {IDLE, RD_WAIT} state_t;
endpackage

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrapping RAM address pointer with increment enable
module ram_fifo_ptr
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);
  // advance on each access; natural overflow wraps modulo DEPTH
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (inc) ptr <= ptr + ADDR_W'(1);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller over a single-port registered-read RAM; RAM_FIFO_BYPASS_EN enables empty-FIFO bypass
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enb,
  output logic              ram_read_enb,
  input  logic [DATA_W-1:0] ram_data_out
);
  state_t            state;
  logic [ADDR_W:0]   mem_count;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              read_issue, write_issue, bypass, push_hs, pop_hs;

  // RAM strobes are combinational so a read issued now lands in pop_data two edges later; reads win the port
  always_comb begin
    read_issue    = (state == IDLE) && (mem_count != '0) && !pop_valid;
    push_ready    = !reset && (mem_count < (ADDR_W+1)'(DEPTH)) && !read_issue;
    push_hs       = push_valid && push_ready;
`ifdef RAM_FIFO_BYPASS_EN
    bypass        = push_hs && (state == IDLE) && (mem_count == '0) && !pop_valid;
`else
    bypass        = 1'b0;
`endif
    write_issue   = push_hs && !bypass;
    pop_hs        = pop_valid && pop_ready;
    ram_read_enb  = read_issue;
    ram_write_enb = write_issue;
    ram_address   = read_issue ? rd_ptr : wr_ptr;
    ram_data_in   = push_data;
  end

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (.clk(clk), .reset(reset), .inc(write_issue), .ptr(wr_ptr));
  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (.clk(clk), .reset(reset), .inc(read_issue),  .ptr(rd_ptr));

  // read FSM plus occupancy counters and the output word register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      mem_count <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      state     <= read_issue ? RD_WAIT : IDLE;
      mem_count <= write_issue ? mem_count + (ADDR_W+1)'(1) : read_issue ? mem_count - (ADDR_W+1)'(1) : mem_count;
      count     <= (push_hs && !pop_hs) ? count + (ADDR_W+1)'(1) : (pop_hs && !push_hs) ? count - (ADDR_W+1)'(1) : count;
      pop_valid <= (state == RD_WAIT) || bypass || (pop_valid && !pop_ready);
      pop_data  <= (state == RD_WAIT) ? ram_data_out : bypass ? push_data : pop_data;
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed and random checks of ram_fifo_ctrl against a queue scoreboard and a 32x8 RAM model
module tb_ram_fifo_ctrl;
`ifdef RAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push_valid = 1'b0;
  logic       pop_ready = 1'b0;
  logic [7:0] push_data = '0;
  logic       push_ready, pop_valid, ram_write_enb, ram_read_enb;
  logic [7:0] pop_data, ram_data_in;
  logic [5:0] count;
  logic [4:0] ram_address;
  wire  [7:0] ram_data_out;
  wire        ram_rst_n = ~reset;

  int checks = 0;
  int failures = 0;
  int mcount = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] sb[$];

  logic [7:0] mem [32];
  logic [7:0] ram_q;
  logic       ram_oe;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enb(ram_write_enb), .ram_read_enb(ram_read_enb),
    .ram_data_out(ram_data_out)
  );

  always @(posedge clk or negedge ram_rst_n)
    if (!ram_rst_n) begin
      ram_oe <= 1'b0;
      ram_q  <= '0;
    end else begin
      if (ram_write_enb) mem[ram_address] <= ram_data_in;
      ram_oe <= ram_read_enb;
      if (ram_read_enb) ram_q <= mem[ram_address];
    end
  assign ram_data_out = ram_oe ? ram_q : 8'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target, input int budget, input string tag);
    int n = 0;
    while (count != 6'(target) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(count), 32'(target));
  endtask

  task automatic push_word(input logic [7:0] d);
    int n = 0;
    push_valid = 1'b1;
    push_data  = d;
    while (!push_ready && n < 20) begin
      tick();
      n++;
    end
    check("push_ready_wait", 32'(push_ready), 32'd1);
    tick();
    push_valid = 1'b0;
  endtask

  // scoreboard: record accepted words, compare popped words, track occupancy and RAM address sequencing
  always @(negedge clk)
    if (reset) begin
      sb.delete();
      mcount = 0;
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      check("count", 32'(count), 32'(mcount));
      check("one_access", 32'(ram_read_enb && ram_write_enb), 32'd0);
      if (ram_write_enb) begin
        check("wr_addr", 32'(ram_address), 32'(wr_cnt[4:0]));
        wr_cnt++;
      end
      if (ram_read_enb) begin
        check("rd_addr", 32'(ram_address), 32'(rd_cnt[4:0]));
        rd_cnt++;
      end
      if (push_valid && push_ready) begin
        sb.push_back(push_data);
        mcount++;
      end
      if (pop_valid && pop_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("pop_data", 32'(pop_data), 32'(sb.pop_front()));
        mcount--;
      end
    end

  initial begin
    int n;
    int hs;
    #2 reset = 1'b1;
    repeat (2) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_wr", 32'(ram_write_enb), 32'd0);
    check("rst_rd", 32'(ram_read_enb), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    reset = 1'b0;
    tick();

    push_valid = 1'b1;
    push_data  = 8'hA5;
    check("single_ready", 32'(push_ready), 32'd1);
    tick();
    push_valid = 1'b0;
    n = 1;
    while (!pop_valid && n < 10) begin
      tick();
      n++;
    end
    check("single_latency", 32'(n), 32'(LAT));
    check("single_data", 32'(pop_data), 32'hA5);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    wait_count(0, 5, "single_empty");

    for (int i = 0; i < 33; i++) push_word(i[7:0]);
    wait_count(33, 10, "fill_count");
    check("fill_ready_low", 32'(push_ready), 32'd0);
    check("fill_pop_valid", 32'(pop_valid), 32'd1);
    check("fill_head", 32'(pop_data), 32'h00);
    push_valid = 1'b1;
    push_data  = 8'hEE;
    repeat (3) tick();
    check("full_hold_ready", 32'(push_ready), 32'd0);
    check("full_hold_count", 32'(count), 32'd33);
    push_valid = 1'b0;

    pop_ready = 1'b1;
    wait_count(0, 200, "drain_count");
    pop_ready = 1'b0;
    tick();
    check("drain_pop_valid", 32'(pop_valid), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    hs = 0;
    n = 0;
    while (hs < 100 && n < 3000) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 8'($urandom);
      pop_ready  = 1'($urandom_range(0, 1));
      if (push_valid && push_ready) hs++;
      if (pop_valid && pop_ready) hs++;
      tick();
      n++;
    end
    check("rand_handshakes", 32'(hs >= 100), 32'd1);
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_count(0, 300, "rand_drain");
    pop_ready = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) push_word(8'h30 + i[7:0]);
    wait_count(3, 20, "prio_setup");
    repeat (3) tick();
    check("prio_pop_valid", 32'(pop_valid), 32'd1);
    pop_ready = 1'b1;
    tick();
    pop_ready  = 1'b0;
    push_valid = 1'b1;
    push_data  = 8'h77;
    check("prio_count", 32'(count), 32'd2);
    check("prio_read", 32'(ram_read_enb), 32'd1);
    check("prio_ready_low", 32'(push_ready), 32'd0);
    check("prio_no_write", 32'(ram_write_enb), 32'd0);
    tick();
    check("prio_ready_rdwait", 32'(push_ready), 32'd1);
    check("prio_write_rdwait", 32'(ram_write_enb), 32'd1);
    check("prio_no_read_rdwait", 32'(ram_read_enb), 32'd0);
    tick();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_count(0, 50, "prio_drain");
    pop_ready = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) push_word(8'h50 + i[7:0]);
    wait_count(5, 20, "rst_mid_setup");
    push_valid = 1'b1;
    push_data  = 8'h99;
    reset = 1'b1;
    tick();
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_mid_wr", 32'(ram_write_enb), 32'd0);
    check("rst_mid_rd", 32'(ram_read_enb), 32'd0);
    check("rst_mid_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(push_ready), 32'd1);
    push_word(8'h5A);
    n = 0;
    while (!pop_valid && n < 10) begin
      tick();
      n++;
    end
    check("post_rst_valid", 32'(pop_valid), 32'd1);
    check("post_rst_data", 32'(pop_data), 32'h5A);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    repeat (2) tick();
    check("final_count", 32'(count), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
